fraction_expand: RTL

- Companion to the reduce-by-GCD exercise block, running the opposite direction. The user enters a reduced digit pair (numerator and denominator, each 0..9) with the board buttons.
- The block then steps a multiplier k upward on a slow tick until the larger digit times k would exceed 9, and finally displays the expanded pair buf[i]*k.
- It sits between the debounced board switches/buttons and the single-digit display driver.

---
 rtl/fraction_expand.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fraction_expand.sv
// Expands a reduced digit pair by the largest multiplier k that keeps both digits <= 9,
// stepping k on a slow tick and then displaying the expanded digits.
module fraction_expand #(
   parameter int unsigned NUM = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       select,
   input  logic       add,
   input  logic       next,
   input  logic [3:0] data_in,
   output logic [3:0] data_out
);

   typedef enum logic [1:0] {
      SETUP  = 2'b00,
      EXPAND = 2'b01,
      SHOW   = 2'b10,
      BAD    = 2'b11
   } state_t;

   state_t      state, state_n;
   logic [3:0]  digit   [2];
   logic [3:0]  digit_n [2];
   logic [3:0]  k, k_n;
   logic [31:0] counter, counter_n;
   logic [3:0]  data_out_n;
   logic        add_q, next_q, add_p, next_p;

   logic [3:0]  cur, m, sum_mod, cur_prod, prod0, prod1;
   logic [4:0]  sum;
   logic [7:0]  step_prod;

   assign add_p  = add & ~add_q;
   assign next_p = next & ~next_q;

   always_comb begin
      cur       = digit[select];
      m         = (digit[0] > digit[1]) ? digit[0] : digit[1];
      sum       = {1'b0, cur} + {1'b0, data_in};
      sum_mod   = (sum >= 5'd20) ? 4'(sum - 5'd20) :
                  (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
      // products formed at 8 bits; the displayed values never exceed 9
      cur_prod  = 4'(8'(cur) * 8'(k));
      prod0     = 4'(8'(digit[0]) * 8'(k));
      prod1     = 4'(8'(digit[1]) * 8'(k));
      step_prod = 8'(m) * (8'(k) + 8'd1);
   end

   always_comb begin
      state_n    = state;
      digit_n    = digit;
      k_n        = k;
      counter_n  = counter;
      data_out_n = data_out;
      case (state)
         SETUP: begin
            data_out_n = cur;
            if (add_p) begin
               digit_n[select] = sum_mod;
               data_out_n      = sum_mod;
            end
            if (next_p) begin
               state_n    = EXPAND;
               k_n        = 4'd1;
               counter_n  = '0;
               data_out_n = 4'd1;
            end
         end
         EXPAND: begin
            data_out_n = k;
            counter_n  = counter + 32'd1;
            if (next_p) begin
               state_n    = SHOW;
               data_out_n = cur_prod;
            end else if (counter == 32'(NUM)) begin
               counter_n = '0;
               if (k < 4'd9 && step_prod <= 8'd9) begin
                  k_n        = k + 4'd1;
                  data_out_n = k + 4'd1;
               end else begin
                  state_n    = SHOW;
                  data_out_n = cur_prod;
               end
            end
         end
         SHOW: begin
            data_out_n = cur_prod;
            if (next_p) begin
               digit_n[0] = prod0;
               digit_n[1] = prod1;
               k_n        = 4'd1;
               counter_n  = '0;
               state_n    = SETUP;
               data_out_n = select ? prod1 : prod0;
            end
         end
         default: begin
            state_n    = SETUP;
            data_out_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SETUP;
         digit[0] <= '0;
         digit[1] <= '0;
         k        <= 4'd1;
         counter  <= '0;
         data_out <= '0;
         add_q    <= 1'b0;
         next_q   <= 1'b0;
      end else begin
         state    <= state_n;
         digit    <= digit_n;
         k        <= k_n;
         counter  <= counter_n;
         data_out <= data_out_n;
         add_q    <= add;
         next_q   <= next;
      end
   end

endmodule
